pattern_detect_lane_scheduler: RTL and testbench

//   Shares a single B-C-C-B-C (Bike/Car) overlapping pattern-detection engine between
//   NUM_LANES vehicle-sensor lanes. A round-robin arbiter accepts at most one symbol per cycle.
//   The engine keeps a separate detector-state context for each lane, so interleaved streams
//   are detected independently. Sits between the lane sensor front-ends and the traffic event logger.

---
 rtl/pattern_detect_lane_scheduler_if.sv | 42 ++++
 rtl/pattern_detect_lane_scheduler.sv | 125 ++++++++++++
 tb/tb_pattern_detect_lane_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_detect_lane_scheduler_if.sv
// Lane-request / match-report bundle for pattern_detect_lane_scheduler.
//   lane_enable  per-lane enable (config)
//   req_valid    lane i offers a symbol
//   req_data     symbol of lane i: 1 = Bike, 0 = Car
//   req_ready    one-hot grant back to the lanes
//   match_valid  one-cycle pulse when a lane completes B-C-C-B-C
//   match_lane   lane index of the last match (held between pulses)
//   match_count  saturating total of matches
// Modports: master = lane front-ends / event logger side, slave = scheduler.
interface pattern_detect_lane_scheduler_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned CNT_W     = 16
);
    logic [NUM_LANES-1:0] lane_enable;
    logic [NUM_LANES-1:0] req_valid;
    logic [NUM_LANES-1:0] req_data;
    logic [NUM_LANES-1:0] req_ready;
    logic                 match_valid;
    logic [LANE_W-1:0]    match_lane;
    logic [CNT_W-1:0]     match_count;

    modport master (
        output lane_enable,
        output req_valid,
        output req_data,
        input  req_ready,
        input  match_valid,
        input  match_lane,
        input  match_count
    );

    modport slave (
        input  lane_enable,
        input  req_valid,
        input  req_data,
        output req_ready,
        output match_valid,
        output match_lane,
        output match_count
    );
endinterface

// File: rtl/pattern_detect_lane_scheduler.sv
// Shares one overlapping B-C-C-B-C detector between NUM_LANES sensor lanes. A round-robin
// arbiter accepts at most one symbol per cycle; each lane keeps its own detector context so
// interleaved streams are detected independently.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   bus_io  slave side of pattern_detect_lane_scheduler_if (requests, grant, match report)
module pattern_detect_lane_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned CNT_W     = 16
) (
    input logic                           clk,
    input logic                           reset,
    pattern_detect_lane_scheduler_if.slave bus_io
);

    localparam int unsigned IdxW = LANE_W + 1;

    localparam logic [2:0] StRst   = 3'd0;
    localparam logic [2:0] StB     = 3'd1;
    localparam logic [2:0] StBc    = 3'd2;
    localparam logic [2:0] StBcc   = 3'd3;
    localparam logic [2:0] StBccb  = 3'd4;
    localparam logic [2:0] StBccbc = 3'd5;

    function automatic logic [2:0] next_state(input logic [2:0] s, input logic bike);
        case (s)
            StRst:   return bike ? StB    : StRst;
            StB:     return bike ? StB    : StBc;
            StBc:    return bike ? StB    : StBcc;
            StBcc:   return bike ? StBccb : StRst;
            StBccb:  return bike ? StB    : StBccbc;
            StBccbc: return bike ? StB    : StBcc;  // overlap: trailing B-C restarts as B-C-C
            default: return StRst;
        endcase
    endfunction

    logic [2:0]           ctx_q [NUM_LANES];
    logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 match_valid_q, match_valid_d;
    logic [LANE_W-1:0]    match_lane_q, match_lane_d;
    logic [CNT_W-1:0]     match_count_q, match_count_d;

    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] grant;
    logic [LANE_W-1:0]    grant_idx;
    logic                 xfer;
    logic [2:0]           ctx_nxt;

    // Reset gates eligibility so req_ready is low throughout reset.
    assign eligible = bus_io.req_valid & bus_io.lane_enable & {NUM_LANES{~reset}};

    // Search forward from rr_ptr with explicit wrap so non-power-of-2 lane counts never
    // address a nonexistent lane.
    always_comb begin
        logic [IdxW-1:0] idx;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            idx = {1'b0, rr_ptr_q} + IdxW'(k);
            if (idx >= IdxW'(NUM_LANES)) begin
                idx = idx - IdxW'(NUM_LANES);
            end
            if (!found && eligible[idx[LANE_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[LANE_W-1:0]] = 1'b1;
                grant_idx               = idx[LANE_W-1:0];
            end
        end
    end

    assign xfer    = |grant;
    assign ctx_nxt = next_state(ctx_q[grant_idx], bus_io.req_data[grant_idx]);

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        match_valid_d = 1'b0;
        match_lane_d  = match_lane_q;
        match_count_d = match_count_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + LANE_W'(1);
            if (ctx_nxt == StBccbc) begin
                match_valid_d = 1'b1;
                match_lane_d  = grant_idx;
                if (match_count_q != {CNT_W{1'b1}}) begin
                    match_count_d = match_count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_lane_q  <= '0;
            match_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            match_valid_q <= match_valid_d;
            match_lane_q  <= match_lane_d;
            match_count_q <= match_count_d;
        end
    end

    // A disabled lane loses any partial pattern; only the granted lane advances.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (reset || !bus_io.lane_enable[i]) begin
                ctx_q[i] <= StRst;
            end else if (xfer && grant_idx == LANE_W'(i)) begin
                ctx_q[i] <= ctx_nxt;
            end
        end
    end

    assign bus_io.req_ready   = grant;
    assign bus_io.match_valid = match_valid_q;
    assign bus_io.match_lane  = match_lane_q;
    assign bus_io.match_count = match_count_q;

endmodule

// File: tb/tb_pattern_detect_lane_scheduler.sv
// Directed bench: main 4-lane instance plus a 3-lane, 2-bit-counter instance for wrap and
// saturation.
module tb_pattern_detect_lane_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    pattern_detect_lane_scheduler_if #(.NUM_LANES(4), .LANE_W(2), .CNT_W(16)) bus4 ();
    pattern_detect_lane_scheduler_if #(.NUM_LANES(3), .LANE_W(2), .CNT_W(2))  bus3 ();

    pattern_detect_lane_scheduler #(.NUM_LANES(4), .LANE_W(2), .CNT_W(16)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus4)
    );

    pattern_detect_lane_scheduler #(.NUM_LANES(3), .LANE_W(2), .CNT_W(2)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 4-lane DUT, check the combinational grant, then clock.
    task automatic cyc4(input logic [3:0] v, input logic [3:0] d, input logic [3:0] en,
                        input logic [3:0] exp_rdy, input string tag);
        bus4.req_valid   = v;
        bus4.req_data    = d;
        bus4.lane_enable = en;
        #1;
        check_eq(tag, 32'(bus4.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc3(input logic [2:0] v, input logic [2:0] d,
                        input logic [2:0] exp_rdy, input string tag);
        bus3.req_valid   = v;
        bus3.req_data    = d;
        bus3.lane_enable = 3'b111;
        #1;
        check_eq(tag, 32'(bus3.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        bus4.req_valid = '0;
        bus4.req_data  = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit seq1 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit seq3 [17];
        logic [3:0] d;
        int k0;
        int k2;
        int nm;

        n_checks = 0;
        n_fails  = 0;
        reset            = 1'b1;
        bus4.lane_enable = 4'hF;
        bus4.req_valid   = 4'hF;
        bus4.req_data    = 4'h0;
        bus3.lane_enable = 3'h7;
        bus3.req_valid   = 3'h0;
        bus3.req_data    = 3'h0;
        @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(bus4.req_ready), 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_mvalid", 32'(bus4.match_valid), 32'h0);
        check_eq("rst_mlane", 32'(bus4.match_lane), 32'h0);
        check_eq("rst_mcount", 32'(bus4.match_count), 32'h0);
        reset = 1'b0;
        bus4.req_valid = '0;

        // Lane 0 alone: B C C B C
        for (int i = 0; i < 5; i++) begin
            cyc4(4'b0001, {3'b000, pat[i]}, 4'hF, 4'b0001, "t1_ready");
            check_eq("t1_mvalid", 32'(bus4.match_valid), (i == 4) ? 32'h1 : 32'h0);
        end
        check_eq("t1_mlane", 32'(bus4.match_lane), 32'h0);
        check_eq("t1_mcount", 32'(bus4.match_count), 32'h1);
        idle4();
        check_eq("t1_pulse_end", 32'(bus4.match_valid), 32'h0);

        // Lane 1 alone: B C C B C C B C, overlapping matches after transfers 5 and 8
        for (int i = 0; i < 8; i++) begin
            cyc4(4'b0010, {2'b00, seq1[i], 1'b0}, 4'hF, 4'b0010, "t2_ready");
            check_eq("t2_mvalid", 32'(bus4.match_valid), (i == 4 || i == 7) ? 32'h1 : 32'h0);
            if (i == 4) check_eq("t2_mcount5", 32'(bus4.match_count), 32'h2);
        end
        check_eq("t2_mlane", 32'(bus4.match_lane), 32'h1);
        check_eq("t2_mcount8", 32'(bus4.match_count), 32'h3);
        idle4();
        check_eq("t2_lane_held", 32'(bus4.match_lane), 32'h1);

        // Lanes 0 and 2 interleaved; rr_ptr is 2 so lane 2 goes first
        for (int c = 0; c < 10; c++) begin
            k0 = c / 2;
            k2 = ((c + 1) / 2 > 4) ? 4 : (c + 1) / 2;
            d = 4'b0000;
            d[0] = pat[k0];
            d[2] = pat[k2];
            cyc4(4'b0101, d, 4'hF, (c % 2 == 0) ? 4'b0100 : 4'b0001, "t3_ready");
            check_eq("t3_mvalid", 32'(bus4.match_valid), (c >= 8) ? 32'h1 : 32'h0);
            if (c == 8) begin
                check_eq("t3_mlane2", 32'(bus4.match_lane), 32'h2);
                check_eq("t3_mcount2", 32'(bus4.match_count), 32'h4);
            end
            if (c == 9) begin
                check_eq("t3_mlane0", 32'(bus4.match_lane), 32'h0);
                check_eq("t3_mcount0", 32'(bus4.match_count), 32'h5);
            end
        end

        // Lane 2 sends B C C B, reset mid-pattern, then C: no match
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b0100, {1'b0, pat[i], 2'b00}, 4'hF, 4'b0100, "t6_ready");
        end
        reset = 1'b1;
        cyc4(4'b0100, 4'b0000, 4'hF, 4'b0000, "t6_rst_ready");
        check_eq("t6_rst_mvalid", 32'(bus4.match_valid), 32'h0);
        check_eq("t6_rst_mlane", 32'(bus4.match_lane), 32'h0);
        check_eq("t6_rst_mcount", 32'(bus4.match_count), 32'h0);
        reset = 1'b0;
        cyc4(4'b0100, 4'b0000, 4'hF, 4'b0100, "t6_post_ready");
        check_eq("t6_post_mvalid", 32'(bus4.match_valid), 32'h0);
        check_eq("t6_post_mcount", 32'(bus4.match_count), 32'h0);

        // All lanes valid: strict rotation starting at rr_ptr = 3
        for (int c = 0; c < 8; c++) begin
            cyc4(4'hF, 4'h0, 4'hF, 4'(1 << ((3 + c) % 4)), "t4_ready");
            check_eq("t4_mvalid", 32'(bus4.match_valid), 32'h0);
        end

        // Lane 3: B C C B, disable one cycle, re-enable, C: partial pattern was discarded
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b1000, {pat[i], 3'b000}, 4'hF, 4'b1000, "t5_ready");
        end
        cyc4(4'b1000, 4'b0000, 4'b0111, 4'b0000, "t5_dis_ready");
        cyc4(4'b1000, 4'b0000, 4'hF, 4'b1000, "t5_re_ready");
        check_eq("t5_mvalid", 32'(bus4.match_valid), 32'h0);
        check_eq("t5_mcount", 32'(bus4.match_count), 32'h0);
        bus4.req_valid = '0;

        // Three-lane instance: rotation wraps 2 -> 0
        for (int c = 0; c < 6; c++) begin
            cyc3(3'b111, 3'b000, 3'(1 << (c % 3)), "n3_ready");
        end

        // Three-lane instance, 2-bit counter: five matches saturate at 3
        seq3[0] = 1'b1; seq3[1] = 1'b0; seq3[2] = 1'b0; seq3[3] = 1'b1; seq3[4] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            seq3[5 + 3*j] = 1'b0;
            seq3[6 + 3*j] = 1'b1;
            seq3[7 + 3*j] = 1'b0;
        end
        nm = 0;
        for (int i = 0; i < 17; i++) begin
            cyc3(3'b001, {2'b00, seq3[i]}, 3'b001, "sat_ready");
            if (i >= 4 && (i - 4) % 3 == 0) begin
                nm++;
                check_eq("sat_mvalid", 32'(bus3.match_valid), 32'h1);
                check_eq("sat_mcount", 32'(bus3.match_count), (nm > 3) ? 32'h3 : 32'(nm));
            end else begin
                check_eq("sat_mvalid", 32'(bus3.match_valid), 32'h0);
            end
        end
        bus3.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
